pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the control FSM state encoding and the hard-wired zero register.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, branch
// flushes, data-memory freeze with timeout error, stall statistics.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_dest_reg,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   err_clear,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   mem_error,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           load_use;
    logic           mem_stall;
    logic           run_like;

    assign load_use = id_ex_mem_read
                   && (id_ex_dest_reg != REG_ZERO)
                   && ((id_ex_dest_reg == id_rs)
                    || (id_uses_rt && (id_ex_dest_reg == id_rt)));

    assign mem_stall = (state == RUN) && mem_req && !mem_ready;

    // The release cycle of a wait behaves as a normal RUN cycle, so a
    // branch held in EX through the freeze is flushed on exit.
    assign run_like = (state == RUN)
                   || ((state == MEM_WAIT) && mem_ready);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mem_error    = 1'b0;
        if (!rst_n) begin
            mem_error = 1'b0;
        end else if (state == ERROR) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_error    = 1'b1;
        end else if (!run_like || mem_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_stall) state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ERROR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ERROR: begin
                    if (err_clear) state <= RUN;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs, id_rt, id_ex_dest_reg;
    logic       id_uses_rt, id_ex_mem_read, branch_taken;
    logic       mem_req, mem_ready, err_clear;

    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_bubble, mem_error;
    logic [15:0] stall_count;

    logic       s_pc, s_ifid, s_idex, s_exmem, s_flush, s_bubble, s_err;
    logic [3:0] s_stall_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .STALL_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_dest_reg(id_ex_dest_reg),
        .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .err_clear(err_clear),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .mem_error(mem_error), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .STALL_CNT_W(4)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_dest_reg(id_ex_dest_reg),
        .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .err_clear(err_clear),
        .pc_write(s_pc), .if_id_write(s_ifid),
        .id_ex_write(s_idex), .ex_mem_write(s_exmem),
        .if_id_flush(s_flush), .id_ex_bubble(s_bubble),
        .mem_error(s_err), .stall_count(s_stall_count)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    // Behavioural model: mode 0=running, 1=waiting on memory, 2=error
    int m_mode = 0;
    int m_waited = 0;
    int m_stalls = 0;
    logic e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bubble, e_err;

    function automatic int sat(int n, int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_outputs();
        bit hz;
        bit frozen;
        hz = id_ex_mem_read && (id_ex_dest_reg != 0) &&
             ((id_ex_dest_reg == id_rs) ||
              (id_uses_rt && (id_ex_dest_reg == id_rt)));
        frozen = (m_mode == 2) ||
                 (m_mode == 1 && !mem_ready) ||
                 (m_mode == 0 && mem_req && !mem_ready);
        e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
        e_flush = 0; e_bubble = 0;
        e_err = (m_mode == 2);
        if (frozen) begin
            e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0;
        end else if (branch_taken) begin
            e_flush = 1; e_bubble = 1;
        end else if (hz) begin
            e_pc = 0; e_ifid = 0; e_bubble = 1;
        end
    endtask

    task automatic model_advance();
        if (!e_pc) m_stalls++;
        case (m_mode)
            0: if (mem_req && !mem_ready) begin
                m_mode = 1;
                m_waited = 0;
            end
            1: if (mem_ready) m_mode = 0;
               else begin
                   m_waited++;
                   if (m_waited == TO) m_mode = 2;
               end
            default: if (err_clear) m_mode = 0;
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
        model_outputs();
        check("pc_write", pc_write, e_pc);
        check("if_id_write", if_id_write, e_ifid);
        check("id_ex_write", id_ex_write, e_idex);
        check("ex_mem_write", ex_mem_write, e_exmem);
        check("if_id_flush", if_id_flush, e_flush);
        check("id_ex_bubble", id_ex_bubble, e_bubble);
        check("mem_error", mem_error, e_err);
        check("stall_count", stall_count, sat(m_stalls, 65535));
        check("small_pc_write", s_pc, e_pc);
        check("small_stall_count", s_stall_count, sat(m_stalls, 15));
        model_advance();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_ex_dest_reg = 0;
        id_uses_rt = 0; id_ex_mem_read = 0; branch_taken = 0;
        mem_req = 0; mem_ready = 0; err_clear = 0;
    endtask

    // Asserts reset mid-cycle with hazards active, then releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        id_ex_mem_read = 1; id_ex_dest_reg = 5; id_rs = 5;
        branch_taken = 1; mem_req = 1; mem_ready = 0;
        #2;
        check("rst_pc_write", pc_write, 1);
        check("rst_if_id_write", if_id_write, 1);
        check("rst_id_ex_write", id_ex_write, 1);
        check("rst_ex_mem_write", ex_mem_write, 1);
        check("rst_flush", if_id_flush, 0);
        check("rst_bubble", id_ex_bubble, 0);
        check("rst_mem_error", mem_error, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_small_count", s_stall_count, 0);
        m_mode = 0; m_waited = 0; m_stalls = 0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
    endtask

    typedef struct {
        logic [4:0] rs, rt, dest;
        logic uses_rt, mread, br, mreq, mrdy;
        logic pc, ifid, bubble, flush;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b0, 1'b0};

        idle();
        @(posedge clk);
        #1;
        do_reset();

        foreach (vecs[i]) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_ex_dest_reg = vecs[i].dest; id_uses_rt = vecs[i].uses_rt;
            id_ex_mem_read = vecs[i].mread; branch_taken = vecs[i].br;
            mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            sample();
            check($sformatf("vec%0d_pc", i), pc_write, vecs[i].pc);
            check($sformatf("vec%0d_ifid", i), if_id_write, vecs[i].ifid);
            check($sformatf("vec%0d_bubble", i), id_ex_bubble, vecs[i].bubble);
            check($sformatf("vec%0d_flush", i), if_id_flush, vecs[i].flush);
            check($sformatf("vec%0d_exmem", i), ex_mem_write, 1);
            advance();
        end
        idle();

        // single load-use stall
        do_reset();
        id_ex_mem_read = 1; id_ex_dest_reg = 5; id_rs = 5;
        sample();
        check("lu_pc_write", pc_write, 0);
        check("lu_bubble", id_ex_bubble, 1);
        advance();
        idle();
        sample();
        check("lu_stall_count", stall_count, 1);
        advance();

        // three-cycle memory wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("memwait_frozen", pc_write, 0);
            advance();
        end
        mem_ready = 1;
        sample();
        check("memwait_release", pc_write, 1);
        advance();
        idle();
        sample();
        check("memwait_stall_count", stall_count, 3);
        advance();

        // timeout into error, then clear
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TO + 1) step();
        sample();
        check("timeout_error", mem_error, 1);
        check("timeout_frozen", ex_mem_write, 0);
        advance();
        mem_req = 0; err_clear = 1;
        step();
        err_clear = 0;
        sample();
        check("err_clear_error", mem_error, 0);
        check("err_clear_pc", pc_write, 1);
        advance();

        // ready on the last wait cycle beats the timeout
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (TO) step();
        mem_ready = 1;
        sample();
        check("race_release", pc_write, 1);
        advance();
        idle();
        sample();
        check("race_no_error", mem_error, 0);
        advance();

        // branch held during a freeze is flushed on exit
        do_reset();
        mem_req = 1; mem_ready = 0; branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("wait_branch_noflush", if_id_flush, 0);
            advance();
        end
        mem_ready = 1;
        sample();
        check("wait_branch_exit_flush", if_id_flush, 1);
        advance();
        idle();

        // 20 stall cycles saturate the 4-bit counter
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (20) step();
        sample();
        check("sat_small_count", s_stall_count, 15);
        check("sat_big_count", stall_count, 20);
        advance();

        // reset while in ERROR, and mid-wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (4) step();
        do_reset();
        sample();
        check("midwait_rst_pc", pc_write, 1);
        check("midwait_rst_err", mem_error, 0);
        advance();

        // randomized traffic
        for (int seg = 0; seg < 4; seg++) begin
            int thr;
            thr = (seg % 2 == 1) ? 1 : 7;
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                id_rs = 5'($urandom_range(0, 3));
                id_rt = 5'($urandom_range(0, 3));
                id_ex_dest_reg = 5'($urandom_range(0, 3));
                id_uses_rt = 1'($urandom_range(0, 1));
                id_ex_mem_read = 1'($urandom_range(0, 1));
                branch_taken = ($urandom_range(0, 4) == 0);
                mem_req = ($urandom_range(0, 9) < 4);
                mem_ready = ($urandom_range(0, 9) < thr);
                err_clear = ($urandom_range(0, 4) == 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
